// File: rtl/ser_piso32.sv
// ser_piso32: 32-bit parallel-in/serial-out link transmitter with one-word holding buffer.
// Define SER_MSB_FIRST_EN to send MSB first instead of the default LSB first.
module ser_piso32 #(
  parameter int   WIDTH      = 32,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             tx_enable,
  output logic             load,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n, hold, hold_n, shifted;
  logic [CW-1:0] count, count_n;
  logic hold_full, hold_full_n, head, accept;
`ifdef SER_MSB_FIRST_EN
  assign shifted = {shift_reg[WIDTH-2:0], 1'b0};
  assign head    = shift_reg[WIDTH-1];
`else
  assign shifted = {1'b0, shift_reg[WIDTH-1:1]};
  assign head    = shift_reg[0];
`endif
  assign accept    = din_valid & din_ready;
  assign din_ready = !hold_full;
  assign tx_enable = state == SHIFT;
  assign dout      = tx_enable ? head : IDLE_LEVEL;
  assign load      = tx_enable && count == LAST;
  assign busy      = tx_enable | hold_full;
  always_comb begin
    state_n     = state;
    shift_n     = shift_reg;
    count_n     = count;
    hold_n      = hold;
    hold_full_n = hold_full;
    if (state == IDLE) begin
      if (accept) begin
        shift_n = din;
        count_n = '0;
        state_n = SHIFT;
      end
    end else if (count == LAST) begin
      // word boundary: chain the next word in with no gap bit
      count_n = '0;
      if (hold_full) begin
        shift_n     = hold;
        hold_full_n = 1'b0;
      end else if (accept) begin
        shift_n = din;
      end else begin
        shift_n = shifted;
        state_n = IDLE;
      end
    end else begin
      shift_n = shifted;
      count_n = count + 1'b1;
      if (accept) begin
        hold_n      = din;
        hold_full_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      count     <= count_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
    end
  end
endmodule

// File: tb/tb_ser_piso32.sv
// tb_ser_piso32: random and directed stimulus against a bit-stream queue model of the link.
module tb_ser_piso32;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready, dout, tx_enable, load, busy;
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] q[$];

  ser_piso32 dut (
    .clock(clock), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .tx_enable(tx_enable), .load(load), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] f;
    f = q.size() > 0 ? q[0] : 2'b00;
    check("dout", 32'(dout), 32'(f[0]));
    check("tx_enable", 32'(tx_enable), 32'(q.size() > 0));
    check("load", 32'(load), 32'(f[1]));
    check("busy", 32'(busy), 32'(q.size() > 0));
    check("din_ready", 32'(din_ready), 32'(q.size() <= 32));
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
`ifdef SER_MSB_FIRST_EN
      q.push_back({i == 31, w[31-i]});
`else
      q.push_back({i == 31, w[i]});
`endif
    end
  endtask

  // one clock cycle: check at negedge, drive, then advance the model at posedge
  task automatic step(input logic v, input logic [31:0] d);
    logic acc;
    check_outputs();
    din_valid = v;
    din = d;
    acc = v && q.size() <= 32;
    @(posedge clock);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) push_word(d);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clock);
    step(1'b1, 32'hA5A50F0F);
    idle(36);
    step(1'b1, 32'h00000001);
    step(1'b1, 32'h80000000);
    idle(70);
    step(1'b1, 32'h12345678);
    idle(31);
    step(1'b1, 32'hFFFFFFFF);
    idle(36);
    step(1'b1, 32'hDEADBEEF);
    step(1'b1, 32'h00000000);
    idle(10);
    #2 rst_n = 1'b0;
    din_valid = 1'b0;
    q.delete();
    #1 check_outputs();
    repeat (3) @(negedge clock);
    check_outputs();
    rst_n = 1'b1;
    step(1'b1, 32'h0000FFFF);
    idle(34);
    for (int i = 0; i < 2000; i++) step($urandom_range(0, 9) < 4, $urandom);
    idle(70);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
